// File: rtl/log_lut_port_arbiter_pkg.sv
// Shared definitions for the log2 LUT port arbiter.
//  - LOG_LUT_ADDR_W / LOG_LUT_DATA_W : default ROM geometry
//  - MAX_REQ / IDW                   : largest supported requester count and its id width
//  - lut_tag_t                       : per-port in-flight tag {valid, requester id}
//  - rr_next()                       : first requesting index scanning from ptr, modulo n
package log_lut_port_arbiter_pkg;

    localparam int LOG_LUT_ADDR_W = 4;
    localparam int LOG_LUT_DATA_W = 20;
    localparam int MAX_REQ        = 8;
    // Ids are sized for the largest legal NUM_REQ so one tag type serves every
    // instance; for smaller NUM_REQ the upper id bits simply stay 0.
    localparam int IDW            = $clog2(MAX_REQ);

    typedef struct packed {
        logic           v;
        logic [IDW-1:0] id;
    } lut_tag_t;

    // Returns the first index k (in ptr, ptr+1, ... mod n order) with req[k] set;
    // returns 0 when nothing is requesting, so callers qualify with |req.
    function automatic logic [IDW-1:0] rr_next(input logic [MAX_REQ-1:0] req,
                                               input logic [IDW-1:0]     ptr,
                                               input int                 n);
        logic [IDW-1:0] sel;
        logic           found;
        int             idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                idx = int'(ptr) + k;
                if (idx >= n) idx = idx - n;
                if (!found && req[idx[IDW-1:0]]) begin
                    sel   = idx[IDW-1:0];
                    found = 1'b1;
                end
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/log_lut_port_arbiter_if.sv
// Requester-side bus of the log2 LUT port arbiter.
//  - req_valid/req_addr/req_ready : lookup request handshake (flat, ADDR_WIDTH slice per requester)
//  - resp_valid/resp_data         : one-cycle response pulse and held data (DATA_WIDTH slice per requester)
//  master = requester lanes, slave = arbiter.
interface log_lut_port_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 20
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            resp_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] resp_data;

    modport master (
        output req_valid, req_addr,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_addr,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/log_lut_port_arbiter_rr_pick2.sv
// Combinational two-winner round-robin picker.
//  - req  : requesting lanes
//  - ptr  : current round-robin start index
//  - ga/va: first requester from ptr (port A winner)
//  - gb/vb: next requester after ga in the same scan (port B winner)
module log_lut_port_arbiter_rr_pick2
    import log_lut_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [IDW-1:0]     ga,
    output logic [IDW-1:0]     gb,
    output logic               va,
    output logic               vb
);
    logic [MAX_REQ-1:0] req_ext;
    logic [MAX_REQ-1:0] req_b;
    logic [IDW-1:0]     ptr_b;

    // Nothing between ptr and ga is requesting, so the second winner is just the
    // first remaining requester scanning on from ga+1.
    always_comb begin
        req_ext              = '0;
        req_ext[NUM_REQ-1:0] = req;
        ga                   = rr_next(req_ext, ptr, NUM_REQ);
        va                   = |req_ext;
        req_b                = req_ext;
        req_b[ga]            = 1'b0;
        ptr_b                = (ga == IDW'(NUM_REQ - 1)) ? '0 : ga + 1'b1;
        gb                   = rr_next(req_b, ptr_b, NUM_REQ);
        vb                   = |req_b;
    end
endmodule

// File: rtl/log_lut_port_arbiter.sv
// Shares the two read ports of the dual-port log2 ROM among NUM_REQ requesters.
//  - clk, rst            : clock, synchronous active-high reset
//  - req_if (slave)      : requester bus (request handshake, response pulse/data)
//  - lut_addr_a/b        : ROM port addresses (0 when the port is unused)
//  - lut_we_a/b          : ROM write enables, tied 0
//  - lut_q_a/b           : ROM read data, LUT_LATENCY cycles after the address
//  - busy                : a granted lookup is still in flight
// Up to two grants per cycle with rotating priority; a tag pipeline matched to
// the ROM latency steers each returning word to the requester that issued it.
module log_lut_port_arbiter
    import log_lut_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_WIDTH  = LOG_LUT_ADDR_W,
    parameter int DATA_WIDTH  = LOG_LUT_DATA_W,
    parameter int LUT_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    log_lut_port_arbiter_if.slave req_if,
    output logic [ADDR_WIDTH-1:0] lut_addr_a,
    output logic [ADDR_WIDTH-1:0] lut_addr_b,
    output logic                  lut_we_a,
    output logic                  lut_we_b,
    input  logic [DATA_WIDTH-1:0] lut_q_a,
    input  logic [DATA_WIDTH-1:0] lut_q_b,
    output logic                  busy
);
    logic [IDW-1:0]                rr_ptr_q, rr_ptr_d;
    lut_tag_t [LUT_LATENCY-1:0]    tag_a_q, tag_a_d;
    lut_tag_t [LUT_LATENCY-1:0]    tag_b_q, tag_b_d;
    logic [NUM_REQ-1:0]            resp_valid_q, resp_valid_d;
    logic [NUM_REQ*DATA_WIDTH-1:0] resp_data_q, resp_data_d;

    logic [IDW-1:0]     ga, gb;
    logic               va, vb;
    logic               gnt_a, gnt_b;
    logic [NUM_REQ-1:0] req_ready;
    lut_tag_t           tail_a, tail_b;

    log_lut_port_arbiter_rr_pick2 #(.NUM_REQ(NUM_REQ)) u_pick (
        .req (req_if.req_valid),
        .ptr (rr_ptr_q),
        .ga  (ga),
        .gb  (gb),
        .va  (va),
        .vb  (vb)
    );

    // No grants while in reset, so nothing is issued that reset would orphan.
    assign gnt_a = va & ~rst;
    assign gnt_b = vb & ~rst;

    always_comb begin
        req_ready  = '0;
        lut_addr_a = '0;
        lut_addr_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_a && ga == IDW'(i)) begin
                req_ready[i] = 1'b1;
                lut_addr_a   = req_if.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
            if (gnt_b && gb == IDW'(i)) begin
                req_ready[i] = 1'b1;
                lut_addr_b   = req_if.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // Pointer moves past the last winner; wrap to 0 is spelled out because
    // NUM_REQ need not be a power of two.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_b)
            rr_ptr_d = (gb == IDW'(NUM_REQ - 1)) ? '0 : gb + 1'b1;
        else if (gnt_a)
            rr_ptr_d = (ga == IDW'(NUM_REQ - 1)) ? '0 : ga + 1'b1;
    end

    // Tag pipeline: stage 0 captures the grant, the tail lines up with lut_q.
    always_comb begin
        tag_a_d       = tag_a_q;
        tag_b_d       = tag_b_q;
        tag_a_d[0].v  = gnt_a;
        tag_a_d[0].id = ga;
        tag_b_d[0].v  = gnt_b;
        tag_b_d[0].id = gb;
        for (int k = 1; k < LUT_LATENCY; k++) begin
            tag_a_d[k] = tag_a_q[k-1];
            tag_b_d[k] = tag_b_q[k-1];
        end
    end

    assign tail_a = tag_a_q[LUT_LATENCY-1];
    assign tail_b = tag_b_q[LUT_LATENCY-1];

    // The picker never returns the same id on both ports, so the two writes
    // below never target the same slice.
    always_comb begin
        resp_valid_d = '0;
        resp_data_d  = resp_data_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (tail_a.v && tail_a.id == IDW'(i)) begin
                resp_valid_d[i]                       = 1'b1;
                resp_data_d[i*DATA_WIDTH +: DATA_WIDTH] = lut_q_a;
            end
            if (tail_b.v && tail_b.id == IDW'(i)) begin
                resp_valid_d[i]                       = 1'b1;
                resp_data_d[i*DATA_WIDTH +: DATA_WIDTH] = lut_q_b;
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < LUT_LATENCY; k++)
            busy = busy | tag_a_q[k].v | tag_b_q[k].v;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            tag_a_q      <= '0;
            tag_b_q      <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            tag_a_q      <= tag_a_d;
            tag_b_q      <= tag_b_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign req_if.req_ready  = req_ready;
    assign req_if.resp_valid = resp_valid_q;
    assign req_if.resp_data  = resp_data_q;
    assign lut_we_a          = 1'b0;
    assign lut_we_b          = 1'b0;
endmodule

// File: tb/tb_log_lut_port_arbiter.sv
// Bench for log_lut_port_arbiter: two instances (LUT_LATENCY 1 and 3) share one
// stimulus stream; each has a ROM model q = {addr, 16'hA5A5} and a scoreboard.
module tb_log_lut_port_arbiter;
    localparam int NR = 4;
    localparam int AW = 4;
    localparam int DW = 20;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            due;
    } sb_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [NR-1:0]  rv;
    logic [NR*AW-1:0] ra;
    int             cyc = 0;
    int             n_chk = 0;
    int             n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int LAT = (g == 0) ? 1 : 3;

        log_lut_port_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
        logic [AW-1:0]           la, lb;
        logic                    wa, wb, bsy;
        logic [LAT-1:0][DW-1:0]  qa_p, qb_p;

        assign bus.req_valid = rv;
        assign bus.req_addr  = ra;

        log_lut_port_arbiter #(
            .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LUT_LATENCY(LAT)
        ) dut (
            .clk        (clk),
            .rst        (rst),
            .req_if     (bus),
            .lut_addr_a (la),
            .lut_addr_b (lb),
            .lut_we_a   (wa),
            .lut_we_b   (wb),
            .lut_q_a    (qa_p[LAT-1]),
            .lut_q_b    (qb_p[LAT-1]),
            .busy       (bsy)
        );

        // ROM model: registered read plus extra delay stages.
        always @(posedge clk) begin
            qa_p[0] <= {la, 16'hA5A5};
            qb_p[0] <= {lb, 16'hA5A5};
            for (int k = LAT - 1; k > 0; k--) begin
                qa_p[k] <= qa_p[k-1];
                qb_p[k] <= qb_p[k-1];
            end
        end

        sb_t              sb[$];
        sb_t              e;
        int               mptr = 0;
        int               ga, gb, left;
        logic [NR-1:0]    exp_rv, exp_rdy;
        logic [NR*DW-1:0] exp_data = '0;
        logic [AW-1:0]    exp_la, exp_lb;
        logic             exp_busy;

        always @(negedge clk) begin
            if (cyc >= 1) begin
                exp_rv = '0;
                while (sb.size() > 0 && sb[0].due <= cyc) begin
                    e = sb.pop_front();
                    exp_rv[e.id] = 1'b1;
                    exp_data[e.id*DW +: DW] = e.data;
                end
                chk($sformatf("L%0d resp_valid", LAT), bus.resp_valid, exp_rv);
                chk($sformatf("L%0d resp_data", LAT), bus.resp_data, exp_data);

                exp_busy = 1'b0;
                foreach (sb[j]) if (sb[j].due - LAT <= cyc) exp_busy = 1'b1;
                chk($sformatf("L%0d busy", LAT), bsy, exp_busy);

                ga = -1;
                gb = -1;
                if (!rst) begin
                    for (int k = 0; k < NR; k++) begin
                        int i;
                        i = (mptr + k) % NR;
                        if (rv[i]) begin
                            if (ga < 0) ga = i;
                            else if (gb < 0) gb = i;
                        end
                    end
                end
                exp_rdy = '0;
                exp_la  = '0;
                exp_lb  = '0;
                if (ga >= 0) begin exp_rdy[ga] = 1'b1; exp_la = ra[ga*AW +: AW]; end
                if (gb >= 0) begin exp_rdy[gb] = 1'b1; exp_lb = ra[gb*AW +: AW]; end
                chk($sformatf("L%0d req_ready", LAT), bus.req_ready, exp_rdy);
                chk($sformatf("L%0d lut_addr_a", LAT), la, exp_la);
                chk($sformatf("L%0d lut_addr_b", LAT), lb, exp_lb);
                chk($sformatf("L%0d lut_we", LAT), {wa, wb}, 2'b00);

                if (rst) begin
                    mptr     = 0;
                    sb.delete();
                    exp_data = '0;
                end else begin
                    if (ga >= 0) sb.push_back('{id: ga, data: {ra[ga*AW +: AW], 16'hA5A5}, due: cyc + LAT + 1});
                    if (gb >= 0) sb.push_back('{id: gb, data: {ra[gb*AW +: AW], 16'hA5A5}, due: cyc + LAT + 1});
                    if (gb >= 0)      mptr = (gb + 1) % NR;
                    else if (ga >= 0) mptr = (ga + 1) % NR;
                end
                left = sb.size();
            end
        end
    end

    // Apply one cycle of stimulus, then advance to just after the next edge.
    task automatic step(input logic [NR-1:0] v, input logic [NR*AW-1:0] a, input logic r);
        rv  = v;
        ra  = a;
        rst = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        rv  = '0;
        ra  = '0;
        @(posedge clk);
        #1;
        step('0, '0, 1'b1);
        step('0, '0, 1'b0);

        // Single requester 2, address 3.
        step(4'b0100, 16'h0300, 1'b0);
        repeat (5) step('0, '0, 1'b0);

        // All four requesting continuously.
        repeat (8) step(4'hF, 16'($urandom), 1'b0);
        repeat (3) step('0, '0, 1'b0);

        // Move pointer to 3 via a lone request from 2, then wrap case 4'b1001.
        step(4'b0100, 16'($urandom), 1'b0);
        step(4'b1001, 16'h5A3C, 1'b0);
        step(4'hF, 16'($urandom), 1'b0);
        repeat (5) step('0, '0, 1'b0);

        // Requester 1, address 7 (exercises the latency-3 instance).
        step(4'b0010, 16'h0070, 1'b0);
        repeat (6) step('0, '0, 1'b0);

        // Reset while lookups are in flight; requests held during reset are refused.
        step(4'hF, 16'($urandom), 1'b0);
        step(4'hF, 16'($urandom), 1'b1);
        repeat (5) step('0, '0, 1'b0);

        // Idle stretch, then confirm arbitration resumes from the held pointer.
        step(4'b0110, 16'($urandom), 1'b0);
        repeat (10) step('0, '0, 1'b0);
        repeat (2) step(4'hF, 16'($urandom), 1'b0);

        // Random traffic.
        repeat (60) step(4'($urandom), 16'($urandom), 1'b0);
        repeat (8) step('0, '0, 1'b0);

        chk("L1 pending", u[0].left, 0);
        chk("L3 pending", u[1].left, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
